// File: rtl/exp_unit_arbiter.sv
// exp_unit_arbiter: shares one single-issue, in-order BF16 exp unit among N_REQ
// requesters. The issue side uses round-robin arbitration. A grant that the unit
// has stalled is locked until the unit accepts it. Every issued requester id is
// pushed into an in-order tag FIFO, and the FIFO head steers each returning
// result back to the requester that issued it.
// Optional feature: define ARB_STATS_EN to add the grant_count port. The port
// carries saturating per-requester 16-bit issue counters.
module exp_unit_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_OUTST = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    unit_in_valid,
  input  logic                    unit_in_ready,
  output logic [DATA_W-1:0]       unit_in_data,
  input  logic                    unit_out_valid,
  output logic                    unit_out_ready,
  input  logic [DATA_W-1:0]       unit_out_data,
  output logic                    busy,
  output logic                    err_orphan
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     grant_count
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_st_e;

  lock_st_e           lock_q, lock_d;
  logic [ID_W-1:0]    locked_id_q, locked_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    tag_mem_q [MAX_OUTST];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_orphan_q, err_orphan_d;

  logic [ID_W-1:0]    grant_rr;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    head;
  logic               can_issue;
  logic               empty;
  logic               issue;
  logic               pop;

  // Wrapping increment for the FIFO pointers, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Wrapping increment for requester ids (mod N_REQ).
  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty     = (cnt_q == '0);
  assign can_issue = (cnt_q < CNT_W'(MAX_OUTST));
  assign head      = tag_mem_q[rd_ptr_q];

  // Round-robin scan: the first valid requester at or after rr_ptr wins.
  always_comb begin
    logic             found;
    logic [ID_W-1:0]  idx;
    grant_rr = rr_ptr_q;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_rr = idx;
      end
    end
  end

  // Lock FSM next state and issue-side outputs. A stalled grant is held
  // until the unit accepts it.
  always_comb begin
    lock_d        = lock_q;
    locked_id_d   = locked_id_q;
    grant         = (lock_q == ST_LOCKED) ? locked_id_q : grant_rr;
    unit_in_valid = can_issue && ((|req_valid) || (lock_q == ST_LOCKED));
    issue         = unit_in_valid && unit_in_ready;
    req_ready     = '0;
    if (issue) begin
      req_ready[grant] = 1'b1;
      lock_d           = ST_OPEN;
    end else if (unit_in_valid) begin
      lock_d      = ST_LOCKED;
      locked_id_d = grant;
    end
  end

  assign unit_in_data = req_data[int'(grant)*DATA_W +: DATA_W];

  // Return path: only the FIFO head may take the result, and only if it is ready.
  always_comb begin
    rsp_valid      = '0;
    unit_out_ready = !empty && rsp_ready[head];
    pop            = unit_out_valid && unit_out_ready;
    if (unit_out_valid && !empty) begin
      rsp_valid[head] = 1'b1;
    end
  end

  assign rsp_data = unit_out_data;

  // Next-state calculation for the arbitration pointer, the tag FIFO, the
  // outstanding count and the orphan flag.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    err_orphan_d = err_orphan_q | (unit_out_valid && empty);
    if (issue) begin
      rr_ptr_d = id_inc(grant);
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers. A reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= ST_OPEN;
      rr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Data-side storage. The locked id and the FIFO entries are only read
  // while the lock flag or the count marks them as valid, so they need no reset.
  always_ff @(posedge clk) begin
    locked_id_q <= locked_id_d;
    if (issue) begin
      tag_mem_q[wr_ptr_q] <= grant;
    end
  end

  assign busy       = (cnt_q != '0) || unit_in_valid;
  assign err_orphan = err_orphan_q;

`ifdef ARB_STATS_EN
  logic [15:0] gcnt_q [N_REQ];

  // Per-requester issue counters that saturate at their maximum value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        gcnt_q[i] <= '0;
      end else if (issue && (grant == ID_W'(i))) begin
        gcnt_q[i] <= sat_inc16(gcnt_q[i]);
      end
    end
  end

  // Flatten the counters onto the grant_count port.
  always_comb begin
    grant_count = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_count[i*16 +: 16] = gcnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_exp_unit_arbiter.sv
// Testbench for exp_unit_arbiter. The bench runs directed scenarios followed by
// randomized traffic, checked against a queue-based reference model. A
// behavioural in-order exp unit returns operand ^ uxor.
module tb_exp_unit_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MO = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              unit_in_valid;
  logic              unit_in_ready;
  logic [DW-1:0]     unit_in_data;
  logic              unit_out_valid;
  logic              unit_out_ready;
  logic [DW-1:0]     unit_out_data;
  logic              busy;
  logic              err_orphan;
`ifdef ARB_STATS_EN
  logic [N*16-1:0]   grant_count;
`endif

  exp_unit_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .unit_in_valid(unit_in_valid), .unit_in_ready(unit_in_ready), .unit_in_data(unit_in_data),
    .unit_out_valid(unit_out_valid), .unit_out_ready(unit_out_ready), .unit_out_data(unit_out_data),
    .busy(busy), .err_orphan(err_orphan)
`ifdef ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  // reference model state
  int          mq[$];
  int          rr_m;
  int          lockid;
  bit          orph_m;
  logic [15:0] uq[$];
  logic [15:0] iss_q [N][$];

  // stimulus state
  logic [N-1:0] pend;
  logic [15:0]  pdata [N];
  int           refill_pct;
  bit           rand_mode;
  bit           uov_en;
  bit           force_orphan;
  logic [15:0]  uxor;
  bit           log_grants;
  int           gq[$];

  // observations from the most recent cycle
  logic         obs_uiv;
  logic [N-1:0] obs_rr;
  logic [15:0]  obs_uid;
  logic [N-1:0] obs_rv;
  logic [15:0]  obs_rd;
  logic         obs_uor;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend[i];
      req_data[i*DW +: DW]    = pdata[i];
    end
    unit_out_valid = force_orphan || (uov_en && uq.size() > 0);
    unit_out_data  = (uq.size() > 0) ? (uq[0] ^ uxor) : 16'hDEAD;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    pend          = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    force_orphan  = 1'b0;
    uov_en        = 1'b0;
    unit_in_ready = 1'b0;
    rsp_ready     = '0;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    uq.delete();
    for (int i = 0; i < N; i++) iss_q[i].delete();
    rr_m   = 0;
    lockid = -1;
    orph_m = 1'b0;
    apply();
    #1;
    chk("rst_unit_in_valid", unit_in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_unit_out_ready", unit_out_ready, 0);
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic tick();
    int           g;
    int           head;
    int           j;
    bit           can, e_uiv, e_issue, e_pop, empty, e_uor, e_busy;
    logic [N-1:0] e_rr, e_rv;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && int'($urandom_range(0, 99)) < refill_pct) begin
        pend[i]  = 1'b1;
        pdata[i] = 16'($urandom);
      end
    end
    if (rand_mode) begin
      unit_in_ready = ($urandom_range(0, 3) != 0);
      uov_en        = ($urandom_range(0, 2) != 0);
      rsp_ready     = N'($urandom);
    end
    apply();
    #1;
    obs_uiv = unit_in_valid;
    obs_rr  = req_ready;
    obs_uid = unit_in_data;
    obs_rv  = rsp_valid;
    obs_rd  = rsp_data;
    obs_uor = unit_out_ready;
    if (log_grants) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) gq.push_back(i);
    end

    can = (mq.size() < MO);
    g   = -1;
    if (lockid >= 0) g = lockid;
    else begin
      for (int k = 0; k < N; k++) begin
        j = (rr_m + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    e_uiv   = can && (g >= 0);
    e_issue = e_uiv && unit_in_ready;
    e_rr    = e_issue ? N'(1 << g) : '0;
    empty   = (mq.size() == 0);
    head    = empty ? 0 : mq[0];
    e_rv    = (unit_out_valid && !empty) ? N'(1 << head) : '0;
    e_uor   = !empty && rsp_ready[head];
    e_pop   = unit_out_valid && e_uor;
    e_busy  = !empty || e_uiv;

    chk("unit_in_valid", unit_in_valid, e_uiv);
    chk("req_ready", req_ready, e_rr);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("unit_out_ready", unit_out_ready, e_uor);
    chk("busy", busy, e_busy);
    chk("err_orphan", err_orphan, orph_m);
    if (e_uiv) chk("unit_in_data", unit_in_data, pdata[g]);
    if (e_rv != '0) chk("rsp_data", rsp_data, unit_out_data);
    if (e_pop && iss_q[head].size() > 0) chk("e2e_result", rsp_data, iss_q[head][0] ^ uxor);

    @(posedge clk);
    if (e_pop) begin
      void'(mq.pop_front());
      void'(uq.pop_front());
      if (iss_q[head].size() > 0) void'(iss_q[head].pop_front());
    end
    if (e_issue) begin
      mq.push_back(g);
      uq.push_back(pdata[g]);
      iss_q[g].push_back(pdata[g]);
      rr_m    = (g + 1) % N;
      lockid  = -1;
      pend[g] = 1'b0;
    end else if (e_uiv) begin
      lockid = g;
    end
    if (unit_out_valid && empty) orph_m = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rand_mode = 1'b0; refill_pct = 0; uxor = 16'h0000; log_grants = 1'b0;
    pend = '0; force_orphan = 1'b0; uov_en = 1'b0; unit_in_ready = 1'b0; rsp_ready = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    apply();
    @(negedge clk);

    // 1: reset state with nothing requesting
    do_reset();
    repeat (2) tick();

    // 2: all requesters valid -> grants 0,1,2,3,0
    do_reset();
    refill_pct = 100; unit_in_ready = 1'b1; uov_en = 1'b1; rsp_ready = '1;
    gq.delete(); log_grants = 1'b1;
    repeat (5) tick();
    log_grants = 1'b0; refill_pct = 0;
    chk("t2_grant_count", gq.size(), 5);
    for (int k = 0; k < 5; k++) chk("t2_grant_order", (gq.size() > k) ? gq[k] : -1, k % 4);

    // 3: stalled grant to req0 stays locked while req1 (now ahead in rr) asserts
    do_reset();
    unit_in_ready = 1'b1; uov_en = 1'b1; rsp_ready = '1;
    pend[0] = 1'b1; pdata[0] = 16'h1111;
    repeat (2) tick();
    unit_in_ready = 1'b0;
    pend[0] = 1'b1; pdata[0] = 16'h1234;
    tick();
    chk("t3_stall_valid", obs_uiv, 1);
    chk("t3_stall_ready", obs_rr, 0);
    pend[1] = 1'b1; pdata[1] = 16'h5678;
    repeat (2) begin
      tick();
      chk("t3_hold_data", obs_uid, 16'h1234);
      chk("t3_hold_ready", obs_rr, 0);
    end
    unit_in_ready = 1'b1;
    tick();
    chk("t3_accept_req0", obs_rr, 4'b0001);
    tick();
    chk("t3_then_req1", obs_rr, 4'b0010);
    repeat (3) tick();

    // 4: issue ids 2 then 1, results steered back in issue order
    do_reset();
    unit_in_ready = 1'b1; rsp_ready = '1;
    pend[2] = 1'b1; pdata[2] = 16'h3F80;
    tick();
    pend[1] = 1'b1; pdata[1] = 16'h4000;
    tick();
    uov_en = 1'b1;
    tick();
    chk("t4_rsp_valid_a", obs_rv, 4'b0100);
    chk("t4_rsp_data_a", obs_rd, 16'h3F80);
    tick();
    chk("t4_rsp_valid_b", obs_rv, 4'b0010);
    chk("t4_rsp_data_b", obs_rd, 16'h4000);

    // 5: full with head-of-line backpressure, no pop bypass into issue
    do_reset();
    unit_in_ready = 1'b1; uov_en = 1'b1; rsp_ready = '0;
    pend[0] = 1'b1; pend[1] = 1'b1; pdata[0] = 16'hAAAA; pdata[1] = 16'hBBBB;
    repeat (2) tick();
    pend[2] = 1'b1; pdata[2] = 16'hCCCC;
    tick();
    chk("t5_full_no_issue", obs_uiv, 0);
    chk("t5_full_no_ready", obs_uor, 0);
    rsp_ready = '1;
    tick();
    chk("t5_pop", obs_uor, 1);
    chk("t5_no_bypass", obs_rr, 0);
    tick();
    chk("t5_issue_after_pop", obs_rr, 4'b0100);
    repeat (3) tick();

    // 6: orphan result with an empty FIFO
    do_reset();
    force_orphan = 1'b1;
    tick();
    chk("t6_orphan_no_ready", obs_uor, 0);
    chk("t6_orphan_no_rsp", obs_rv, 0);
    chk("t6_orphan_set", err_orphan, 1);
    force_orphan = 1'b0;
    repeat (3) tick();
    chk("t6_orphan_sticky", err_orphan, 1);
    do_reset();

`ifdef ARB_STATS_EN
    unit_in_ready = 1'b1; uov_en = 1'b1; rsp_ready = '1;
    repeat (5) begin
      pend[3] = 1'b1; pdata[3] = 16'($urandom);
      tick();
    end
    chk("t6_grant_count3", grant_count[3*16 +: 16], 16'd5);
    do_reset();
`endif

    // randomized traffic, with a reset in the middle of operation
    rand_mode = 1'b1; refill_pct = 40; uxor = 16'h5A5A;
    repeat (300) tick();
    do_reset();
    repeat (300) tick();
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
